// File: rtl/joker_power_seq.sv
// -----------------------------------------------------------------------------
// joker_power_seq
//
// Board reset / power-enable sequencer.
//  - Holds the system reset for BOOT_DELAY_US after reset release. At the end of
//    boot it loads DEFAULT_MASK as the target enable mask.
//  - Generates a 1 us tick pulse and a free-running 32-bit microsecond counter.
//  - Generates the USB PHY strapping qualifier, which is sys_reset_n delayed by
//    SYNC_STAGES clocks.
//  - Drives NUM_CH power-enable lines toward the target mask:
//      * Enables rise one at a time, lowest index first, with a STEP_DELAY_US
//        settle gap after each one.
//      * Enables that leave the target drop on the next clock.
//
// Optional build macro:
//   JOKER_PWR_FAULT_EN  Adds the i_fault_n / o_fault_flag ports and the
//                       FAULT_MASK parameter. While the synchronised fault is
//                       low, the FAULT_MASK channels are forced off and cannot
//                       be requested.
//
// Ports:
//   i_clk           system clock
//   i_reset         asynchronous, active-high reset
//   i_fault_n       (JOKER_PWR_FAULT_EN only) active-low fault input, asynchronous
//   o_fault_flag    (JOKER_PWR_FAULT_EN only) sticky fault indication
//   i_ctrl_req      requested enable mask
//   i_ctrl_valid    1-cycle strobe: latch i_ctrl_req as the new target
//   o_en_out        power-enable outputs
//   o_sys_reset     active-high system reset for the rest of the design
//   o_usb_strapping sys_reset_n delayed SYNC_STAGES clocks
//   o_pulse_1us     1-cycle pulse every microsecond
//   o_count_us      free-running microsecond counter
//   o_seq_busy      enables still pending, or a settle gap is running
//   o_seq_done      1-cycle pulse when o_seq_busy falls
// -----------------------------------------------------------------------------
module joker_power_seq #(
    parameter int                CLK_HZ        = 50000000,
    parameter int                NUM_CH        = 8,
    parameter int                BOOT_DELAY_US = 1000000,
    parameter int                STEP_DELAY_US = 1000,
    parameter logic [NUM_CH-1:0] DEFAULT_MASK  = 8'hB3,
    parameter int                SYNC_STAGES   = 3
`ifdef JOKER_PWR_FAULT_EN
    ,
    parameter logic [NUM_CH-1:0] FAULT_MASK    = 8'h40
`endif
) (
    input  logic              i_clk,
    input  logic              i_reset,
`ifdef JOKER_PWR_FAULT_EN
    input  logic              i_fault_n,
    output logic              o_fault_flag,
`endif
    input  logic [NUM_CH-1:0] i_ctrl_req,
    input  logic              i_ctrl_valid,
    output logic [NUM_CH-1:0] o_en_out,
    output logic              o_sys_reset,
    output logic              o_usb_strapping,
    output logic              o_pulse_1us,
    output logic [31:0]       o_count_us,
    output logic              o_seq_busy,
    output logic              o_seq_done
);

    localparam int DIV    = CLK_HZ / 1000000;
    localparam int DIV_W  = $clog2(DIV);
    localparam int BOOT_W = $clog2(BOOT_DELAY_US + 1);
    localparam int STEP_W = $clog2(STEP_DELAY_US + 1);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_IDLE,
        ST_STEP_WAIT
    } state_t;

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic                r_pulse;
    logic [31:0]         r_count_us;
    logic [BOOT_W-1:0]   r_boot_cnt;
    logic [STEP_W-1:0]   r_step_cnt;
    logic [NUM_CH-1:0]   r_target;
    logic [NUM_CH-1:0]   r_en;
    logic                r_sys_reset;
    logic                r_busy;
    logic                r_done;
    logic [SYNC_STAGES-1:0] r_strap;

    // ---------------------------------------------------------------------
    // Combinational next-state signals
    // ---------------------------------------------------------------------
    state_t              w_state_next;
    logic [BOOT_W-1:0]   w_boot_cnt_next;
    logic [STEP_W-1:0]   w_step_cnt_next;
    logic [NUM_CH-1:0]   w_target_next;
    logic [NUM_CH-1:0]   w_en_next;
    logic                w_sys_reset_next;
    logic                w_busy_next;

    logic                w_tick;
    logic [NUM_CH-1:0]   w_fmask;       // channels currently forced off by a fault
    logic [NUM_CH-1:0]   w_target_eff;
    logic [NUM_CH-1:0]   w_pending;
    logic [NUM_CH-1:0]   w_drop;
    logic [NUM_CH-1:0]   w_low;

    // ---------------------------------------------------------------------
    // Optional fault input
    // ---------------------------------------------------------------------
`ifdef JOKER_PWR_FAULT_EN
    // [1:0] form the synchroniser. [2] holds the previous synchronised value,
    // used for edge detection.
    logic [2:0] r_fault_sync;
    logic       r_fault_flag;
    logic       w_fault_assert;

    // The flag is set on the assertion edge, not on the level. This lets a
    // ctrl_valid acknowledge it even while the fault input is still held low.
    assign w_fault_assert = r_fault_sync[2] & ~r_fault_sync[1];
    assign w_fmask        = r_fault_sync[1] ? '0 : FAULT_MASK;
    assign o_fault_flag   = r_fault_flag;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fault_sync <= '1;
            r_fault_flag <= 1'b0;
        end else begin
            r_fault_sync <= {r_fault_sync[1:0], i_fault_n};
            if (w_fault_assert) begin
                r_fault_flag <= 1'b1;
            end else if (i_ctrl_valid && (r_state != ST_BOOT)) begin
                r_fault_flag <= 1'b0;
            end
        end
    end
`else
    assign w_fmask = '0;
`endif

    // ---------------------------------------------------------------------
    // Microsecond tick and counter
    // ---------------------------------------------------------------------
    assign w_tick = (r_div == DIV_W'(DIV - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div      <= '0;
            r_pulse    <= 1'b0;
            r_count_us <= '0;
        end else begin
            r_pulse <= w_tick;
            if (w_tick) begin
                r_div      <= '0;
                r_count_us <= r_count_us + 32'd1;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Enable sequencing
    // ---------------------------------------------------------------------
    assign w_target_eff = r_target & ~w_fmask;
    assign w_pending    = w_target_eff & ~r_en;
    assign w_drop       = r_en & ~w_target_eff;
    // Two's-complement trick: isolate the lowest set bit of the pending mask.
    assign w_low        = w_pending & (~w_pending + NUM_CH'(1));

    always_comb begin
        w_state_next     = r_state;
        w_boot_cnt_next  = r_boot_cnt;
        w_step_cnt_next  = r_step_cnt;
        w_target_next    = r_target;
        w_en_next        = r_en;
        w_sys_reset_next = r_sys_reset;

        case (r_state)
            ST_BOOT: begin
                if (w_tick) begin
                    if (r_boot_cnt == BOOT_W'(BOOT_DELAY_US - 1)) begin
                        w_boot_cnt_next  = '0;
                        w_target_next    = DEFAULT_MASK & ~w_fmask;
                        w_sys_reset_next = 1'b0;
                        w_state_next     = ST_IDLE;
                    end else begin
                        w_boot_cnt_next = r_boot_cnt + BOOT_W'(1);
                    end
                end
            end

            default: begin
                // Newest request wins. Masked channels are refused at entry.
                if (i_ctrl_valid) begin
                    w_target_next = i_ctrl_req & ~w_fmask;
                end else begin
                    w_target_next = w_target_eff;
                end
                w_en_next = r_en & w_target_eff;

                if (r_state == ST_IDLE) begin
                    // Stale channels are removed before a new one is raised.
                    // On a channel swap, the board therefore sees the old rail
                    // drop first, then the new rail start up.
                    if ((w_drop == '0) && (w_pending != '0)) begin
                        w_en_next       = r_en | w_low;
                        w_step_cnt_next = '0;
                        w_state_next    = ST_STEP_WAIT;
                    end
                end else begin
                    if (w_tick) begin
                        if (r_step_cnt == STEP_W'(STEP_DELAY_US - 1)) begin
                            w_state_next = ST_IDLE;
                        end else begin
                            w_step_cnt_next = r_step_cnt + STEP_W'(1);
                        end
                    end
                end
            end
        endcase
    end

    assign w_busy_next = (r_state == ST_STEP_WAIT) ||
                         ((r_state == ST_IDLE) && (w_pending != '0));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_BOOT;
            r_boot_cnt  <= '0;
            r_step_cnt  <= '0;
            r_target    <= '0;
            r_en        <= '0;
            r_sys_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_boot_cnt  <= w_boot_cnt_next;
            r_step_cnt  <= w_step_cnt_next;
            r_target    <= w_target_next;
            r_en        <= w_en_next;
            r_sys_reset <= w_sys_reset_next;
            r_busy      <= w_busy_next;
            r_done      <= r_busy & ~w_busy_next;
        end
    end

    // ---------------------------------------------------------------------
    // USB strapping qualifier: sys_reset_n through a SYNC_STAGES delay line
    // ---------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_strap
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_strap[gi] <= 1'b0;
                end else if (gi == 0) begin
                    r_strap[gi] <= ~r_sys_reset;
                end else begin
                    r_strap[gi] <= r_strap[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign o_en_out        = r_en;
    assign o_sys_reset     = r_sys_reset;
    assign o_usb_strapping = r_strap[SYNC_STAGES-1];
    assign o_pulse_1us     = r_pulse;
    assign o_count_us      = r_count_us;
    assign o_seq_busy      = r_busy;
    assign o_seq_done      = r_done;

endmodule

// File: tb/tb_joker_power_seq.sv
module tb_joker_power_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ctrl_req;
    logic        ctrl_valid;
    logic [7:0]  en_out;
    logic        sys_reset;
    logic        usb_strapping;
    logic        pulse_1us;
    logic [31:0] count_us;
    logic        seq_busy;
    logic        seq_done;
`ifdef JOKER_PWR_FAULT_EN
    logic        fault_n;
    logic        fault_flag;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    // Scoreboard of expected en_out values, in order of change
    logic [7:0] exp_q[$];
    logic [7:0] last_en = 8'h00;
    logic [7:0] mon_exp;
    bit         mon_on = 1'b0;

    always #5 clk = ~clk;

    joker_power_seq #(
        .CLK_HZ        (4000000),
        .NUM_CH        (8),
        .BOOT_DELAY_US (10),
        .STEP_DELAY_US (2),
        .DEFAULT_MASK  (8'h05),
        .SYNC_STAGES   (3)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
`ifdef JOKER_PWR_FAULT_EN
        .i_fault_n       (fault_n),
        .o_fault_flag    (fault_flag),
`endif
        .i_ctrl_req      (ctrl_req),
        .i_ctrl_valid    (ctrl_valid),
        .o_en_out        (en_out),
        .o_sys_reset     (sys_reset),
        .o_usb_strapping (usb_strapping),
        .o_pulse_1us     (pulse_1us),
        .o_count_us      (count_us),
        .o_seq_busy      (seq_busy),
        .o_seq_done      (seq_done)
    );

    // Monitor: count seq_done pulses; compare each en_out change against the scoreboard
    always @(negedge clk) begin
        if (seq_done === 1'b1) done_cnt++;
        if (mon_on && (en_out !== last_en)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL en_seq: en_out changed %h -> %h, no change expected", last_en, en_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (en_out !== mon_exp) begin
                    n_fail++;
                    $display("FAIL en_seq: en_out=%h expected %h", en_out, mon_exp);
                end else begin
                    $display("en_out change -> %h ok", en_out);
                end
            end
            last_en = en_out;
        end
    end

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_en(input logic [7:0] val, input int limit);
        int n = 0;
        while ((en_out !== val) && (n < limit)) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (en_out !== val) begin
            n_fail++;
            $display("FAIL wait_en: en_out=%h never reached %h", en_out, val);
        end
    endtask

    task automatic wait_done(input int start, input int limit);
        int n = 0;
        while ((done_cnt == start) && (n < limit)) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (done_cnt != start + 1) begin
            n_fail++;
            $display("FAIL seq_done_count: got %0d pulses, expected 1", done_cnt - start);
        end
        n_checks++;
        if (seq_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_busy_end: seq_busy=%b expected 0", seq_busy);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL en_seq_left: %0d expected en_out changes never seen", exp_q.size());
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if ({en_out, sys_reset, usb_strapping, pulse_1us, seq_busy, seq_done} !== {8'h00, 5'b10000}) begin
            n_fail++;
            $display("FAIL %s: en=%h sr=%b strap=%b pulse=%b busy=%b done=%b expected 00 1 0 0 0 0",
                     tag, en_out, sys_reset, usb_strapping, pulse_1us, seq_busy, seq_done);
        end
        n_checks++;
        if (count_us !== 32'd0) begin
            n_fail++;
            $display("FAIL %s_count: count_us=%0d expected 0", tag, count_us);
        end
        $display("%s checked", tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ctrl_valid = 1'b0;
        ctrl_req = 8'h00;
`ifdef JOKER_PWR_FAULT_EN
        fault_n = 1'b1;
`endif
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        mon_on = 1'b1;
        release_reset();
    endtask

    // Called right after reset has been released at a negedge
    task automatic test_boot();
        int start = done_cnt;
        logic e_sr, e_strap, e_pulse, e_busy, e_done;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h05);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            e_sr    = (k < 40);
            e_strap = (k >= 43);
            e_pulse = (k >= 4) && (k % 4 == 0);
            e_busy  = (k >= 41) && (k < 57);
            e_done  = (k == 57);
            n_checks++;
            if ({sys_reset, usb_strapping, pulse_1us, seq_busy, seq_done} !==
                {e_sr, e_strap, e_pulse, e_busy, e_done}) begin
                n_fail++;
                $display("FAIL boot_ctl clk %0d: sr/strap/pulse/busy/done=%b%b%b%b%b expected %b%b%b%b%b",
                         k, sys_reset, usb_strapping, pulse_1us, seq_busy, seq_done,
                         e_sr, e_strap, e_pulse, e_busy, e_done);
            end
            n_checks++;
            if (count_us !== 32'(k / 4)) begin
                n_fail++;
                $display("FAIL boot_count clk %0d: count_us=%0d expected %0d", k, count_us, k / 4);
            end
            if (k == 41 || k == 48 || k == 49) begin
                n_checks++;
                if (en_out !== ((k == 49) ? 8'h05 : 8'h01)) begin
                    n_fail++;
                    $display("FAIL boot_en clk %0d: en_out=%h", k, en_out);
                end
            end
        end
        n_checks++;
        if (done_cnt != start + 1) begin
            n_fail++;
            $display("FAIL boot_done_count: got %0d pulses, expected 1", done_cnt - start);
        end
        $display("boot sequence checked, en_out=%h", en_out);
    endtask

    task automatic test_swap();
        int start = done_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h82);
        @(negedge clk);
        ctrl_req = 8'h82;
        ctrl_valid = 1'b1;
        @(negedge clk);
        ctrl_valid = 1'b0;
        wait_done(start, 80);
        n_checks++;
        if (en_out !== 8'h82) begin
            n_fail++;
            $display("FAIL swap_final: en_out=%h expected 82", en_out);
        end
        $display("swap 05->82 checked, en_out=%h", en_out);
    endtask

    task automatic test_newest_wins();
        int start = done_cnt;
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h01);
        @(negedge clk);
        ctrl_req = 8'h0F;
        ctrl_valid = 1'b1;
        @(negedge clk);
        ctrl_valid = 1'b0;
        wait_en(8'h03, 20);
        ctrl_req = 8'h01;
        ctrl_valid = 1'b1;
        @(negedge clk);
        ctrl_valid = 1'b0;
        wait_done(start, 80);
        n_checks++;
        if (en_out !== 8'h01) begin
            n_fail++;
            $display("FAIL newest_final: en_out=%h expected 01", en_out);
        end
        $display("newest-wins 0F then 01 checked, en_out=%h", en_out);
    endtask

    task automatic test_reset_mid();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h00);
        @(negedge clk);
        ctrl_req = 8'h30;
        ctrl_valid = 1'b1;
        @(negedge clk);
        ctrl_valid = 1'b0;
        wait_en(8'h10, 20);
        @(posedge clk);
        n_checks++;
        if (seq_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: seq_busy=%b expected 1 before reset", seq_busy);
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("reset_mid");
        repeat (2) @(negedge clk);
        release_reset();
        test_boot();
    endtask

`ifdef JOKER_PWR_FAULT_EN
    task automatic test_fault();
        int start = done_cnt;
        exp_q.push_back(8'h45);
        @(negedge clk);
        ctrl_req = 8'h45;
        ctrl_valid = 1'b1;
        @(negedge clk);
        ctrl_valid = 1'b0;
        wait_done(start, 80);
        exp_q.push_back(8'h05);
        fault_n = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if ({en_out, fault_flag} !== {8'h05, 1'b1}) begin
            n_fail++;
            $display("FAIL fault_trip: en=%h flag=%b expected 05 1", en_out, fault_flag);
        end
        ctrl_req = 8'h45;
        ctrl_valid = 1'b1;
        @(negedge clk);
        ctrl_valid = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++;
        if ({en_out, fault_flag, seq_busy} !== {8'h05, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL fault_rerequest: en=%h flag=%b busy=%b expected 05 0 0",
                     en_out, fault_flag, seq_busy);
        end
        fault_n = 1'b1;
        $display("fault trip and re-request checked, en_out=%h", en_out);
    endtask
`endif

    initial begin
        test_reset();
        test_boot();
        test_swap();
        test_newest_wins();
        test_reset_mid();
`ifdef JOKER_PWR_FAULT_EN
        test_fault();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
